vram_arbiter: RTL
=================

# vram_arbiter

Slot-based scheduler sharing the single-port 32K×8 VRAM between the VDP tile fetcher (video requester) and the CPU data port (read/write requester). A free-running slot counter, realignable at line start, gives video fixed-priority slots and hands all other slots, plus unused video slots, to the CPU. It drives the `spram32k8` address, write-enable and write-data pins, and returns read data to the owning requester with a fixed latency.

## Interface
- `ADDR_WIDTH`, 15, VRAM address width.
- `SLOT_BITS`, 3, slot counter width; the slot cycle is 2^SLOT_BITS clocks.
- `VIDEO_SLOTS`, 4, slots 0..VIDEO_SLOTS-1 are video-priority. Must be ≤ 2^SLOT_BITS - 1, so at least one CPU-only slot exists.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `line_start`  in  1  slot counter realign; the next cycle is slot 0.
- `vid_req`  in  1  video wants the current slot.
- `vid_addr`  in  ADDR_WIDTH  video read address.
- `vid_data`  out  8  video read data.
- `vid_valid`  out  1  `vid_data`/`vid_tag` valid, one-cycle pulse.
- `vid_tag`  out  SLOT_BITS  slot number the returned data was issued in.
- `cpu_req`  in  1  CPU transaction request; level, held until ack.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_WIDTH  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_ack`  out  1  transaction complete, one-cycle pulse.
- `cpu_rdata`  out  8  CPU read data; valid with `cpu_ack` on reads and held until the next CPU read ack.
- `slot`  out  SLOT_BITS  current slot number.
- `ram_addr`  out  ADDR_WIDTH  VRAM address.
- `ram_we`  out  1  VRAM write enable.
- `ram_wdata`  out  8  VRAM write data.
- `ram_rdata`  in  8  VRAM read data; synchronous, valid the cycle after the address.

## Operation
**Slot counter**
- Increments every clock and wraps from 2^SLOT_BITS-1 to 0.
- `line_start` high in cycle t forces `slot` = 0 in t+1. This overrides normal wrap.

**Ownership in cycle t (combinational from `slot`, `vid_req`, CPU state)**
- If `slot` < VIDEO_SLOTS and `vid_req` = 1, VIDEO owns the slot: `ram_addr` = `vid_addr`, `ram_we` = 0.
- Else if `cpu_req` = 1 and the CPU FSM is IDLE, CPU owns the slot: `ram_addr` = `cpu_addr`, `ram_we` = `cpu_we`, `ram_wdata` = `cpu_wdata`.
- Else the slot is NONE: `ram_addr` = 0, `ram_we` = 0, `ram_wdata` = 0.

**CPU FSM**
- States: IDLE → ISSUED → RETURN → IDLE.
- IDLE → ISSUED on a CPU grant.
- ISSUED → RETURN unconditionally.
- RETURN → IDLE unconditionally, with `cpu_ack` = 1.
- No CPU grant is made outside IDLE, so at most one CPU transaction is in flight.
- Holding `cpu_req` high across the ack starts a new transaction, which can be granted in the cycle after the ack.
- Reads: `cpu_rdata` ← `ram_rdata` is captured in the ISSUED cycle.

**Video pipeline**
- A 2-stage valid/tag shift.
- A grant in cycle t gives `vid_valid` = 1 in t+2, with `vid_data` = `ram_rdata` sampled in t+1 and `vid_tag` = slot(t).
- Video back-to-back grants every cycle are sustained.

**Reset (`reset` = 0 at an edge)**
- `slot` = 0, CPU FSM = IDLE, pipelines cleared.
- `vid_valid` = 0, `cpu_ack` = 0, `vid_data` = 0, `cpu_rdata` = 0, `vid_tag` = 0.
- While `reset` is low, `ram_we` is forced to 0 combinationally and `ram_addr` = 0.
- Mid-operation reset: in-flight transactions are dropped with no ack or valid. A write whose `ram_we` cycle preceded the reset edge has already committed.

## Timing
- Latency is 2 cycles, grant to `vid_valid`/`cpu_ack`, for both reads and writes.
- CPU worst-case wait with `vid_req` held high is VIDEO_SLOTS + 1 cycles to grant.
- CPU maximum throughput is one transaction per 3 cycles.
- `line_start` together with a video-priority slot: ownership in the current cycle uses the current `slot`. Realign affects only the next cycle.
- `cpu_req` dropped while ISSUED or RETURN: the transaction still completes and acks. The requester must ignore the ack.
- `cpu_addr`/`cpu_we`/`cpu_wdata` are sampled only in the grant cycle.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles with `cpu_req` = 1, `cpu_we` = 1 → `ram_we` stays 0, `slot` = 0 on release, then counts 1,2,3…
- **Video slots:** `vid_req` = 1 constantly with `vid_addr` = 0x0100+slot, VRAM preloaded. Expect `vid_valid` in every slot 0–3 issue +2 cycles, with matching `vid_tag` and data. Slots 4–7 go to the CPU or NONE.
- **CPU write then read:** write 0xA5 to 0x1234 issued in slot 5 → ack 2 cycles later. Read of 0x1234 → `cpu_rdata` = 0xA5 with `cpu_ack`.
- **Contention:** CPU request arrives in slot 0 while `vid_req` = 1 → granted in slot 4, acked in slot 6, video data unaffected.
- **Yield and realign:** `vid_req` = 0 in slot 2 → CPU granted in slot 2. Pulse `line_start` in slot 5 → next `slot` = 0.
- **Reset mid-read:** `reset` = 0 in the ISSUED cycle → no `cpu_ack`, FSM IDLE after release, and a new request is granted normally.

Source files
------------

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Slot-based scheduler that shares one single-port 32Kx8 VRAM (spram32k8)
// between the VDP tile fetcher (video) and the CPU data port.
//
// A free-running slot counter decides who owns the RAM each cycle:
//   - slots 0..VIDEO_SLOTS-1 belong to video whenever vid_req is high;
//   - every other slot, and any video slot that video leaves unused, is
//     offered to the CPU (one transaction in flight at a time).
// Read data comes back from the synchronous RAM one cycle after the address.
// It is then registered, so requesters see results two cycles after the grant.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low reset
//   line_start   realign: the cycle after this pulse is slot 0
//   vid_req      video wants the current slot
//   vid_addr     video read address
//   vid_data     video read data           (valid with vid_valid)
//   vid_valid    one-cycle pulse, grant + 2
//   vid_tag      slot the returned video data was issued in
//   cpu_req      CPU request level, held until cpu_ack
//   cpu_we       CPU write (1) / read (0)
//   cpu_addr     CPU address
//   cpu_wdata    CPU write data
//   cpu_ack      one-cycle completion pulse, grant + 2
//   cpu_rdata    CPU read data, held until the next CPU read ack
//   slot         current slot number
//   ram_addr     VRAM address
//   ram_we       VRAM write enable
//   ram_wdata    VRAM write data
//   ram_rdata    VRAM read data (valid the cycle after the address)
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_WIDTH  = 15,
    parameter int SLOT_BITS   = 3,
    parameter int VIDEO_SLOTS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,

    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [7:0]            vid_data,
    output logic                  vid_valid,
    output logic [SLOT_BITS-1:0]  vid_tag,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic                  cpu_ack,
    output logic [7:0]            cpu_rdata,

    output logic [SLOT_BITS-1:0]  slot,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);

    // First slot number that is not video-priority.
    localparam logic [SLOT_BITS-1:0] VIDEO_LIMIT = SLOT_BITS'(VIDEO_SLOTS);

    typedef enum logic [1:0] {
        CPU_IDLE   = 2'd0,
        CPU_ISSUED = 2'd1,
        CPU_RETURN = 2'd2
    } cpu_state_t;

    cpu_state_t           cpu_state_reg;
    logic                 cpu_rd_reg;       // transaction in flight is a read
    logic [7:0]           cpu_rdata_reg;
    logic                 cpu_ack_reg;

    logic [SLOT_BITS-1:0] slot_reg;

    // Video return pipeline: stage 1 is the cycle the RAM presents data,
    // stage 2 is the registered output seen by the fetcher.
    logic                 v1_valid_reg;
    logic [SLOT_BITS-1:0] v1_tag_reg;
    logic                 vid_valid_reg;
    logic [SLOT_BITS-1:0] vid_tag_reg;
    logic [7:0]           vid_data_reg;

    logic                 vid_grant;
    logic                 cpu_grant;

    // ------------------------------------------------------------------
    // Ownership of the current cycle. Video has strict priority in its
    // slots; the CPU can only take a slot while no transaction is in
    // flight. Holding reset low parks the RAM pins at zero.
    // ------------------------------------------------------------------
    always_comb begin
        vid_grant = 1'b0;
        cpu_grant = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (reset) begin
            if ((slot_reg < VIDEO_LIMIT) && vid_req) begin
                vid_grant = 1'b1;
                ram_addr  = vid_addr;
            end else if (cpu_req && (cpu_state_reg == CPU_IDLE)) begin
                cpu_grant = 1'b1;
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_wdata = cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_reg      <= '0;
            cpu_state_reg <= CPU_IDLE;
            cpu_rd_reg    <= 1'b0;
            cpu_rdata_reg <= '0;
            cpu_ack_reg   <= 1'b0;
            v1_valid_reg  <= 1'b0;
            v1_tag_reg    <= '0;
            vid_valid_reg <= 1'b0;
            vid_tag_reg   <= '0;
            vid_data_reg  <= '0;
        end else begin
            // Realign takes precedence over the natural wrap.
            slot_reg <= line_start ? '0 : slot_reg + 1'b1;

            // Video returns: one entry per grant, so back-to-back grants
            // simply stream through.
            v1_valid_reg  <= vid_grant;
            v1_tag_reg    <= slot_reg;
            vid_valid_reg <= v1_valid_reg;
            if (v1_valid_reg) begin
                vid_data_reg <= ram_rdata;
                vid_tag_reg  <= v1_tag_reg;
            end

            cpu_ack_reg <= 1'b0;
            case (cpu_state_reg)
                CPU_IDLE: begin
                    if (cpu_grant) begin
                        cpu_state_reg <= CPU_ISSUED;
                        cpu_rd_reg    <= ~cpu_we;
                    end
                end
                CPU_ISSUED: begin
                    // RAM data for the granted address is on ram_rdata now.
                    cpu_state_reg <= CPU_RETURN;
                    cpu_ack_reg   <= 1'b1;
                    if (cpu_rd_reg) begin
                        cpu_rdata_reg <= ram_rdata;
                    end
                end
                CPU_RETURN: begin
                    cpu_state_reg <= CPU_IDLE;
                end
                default: begin
                    cpu_state_reg <= CPU_IDLE;
                end
            endcase
        end
    end

    assign slot      = slot_reg;
    assign vid_valid = vid_valid_reg;
    assign vid_tag   = vid_tag_reg;
    assign vid_data  = vid_data_reg;
    assign cpu_ack   = cpu_ack_reg;
    assign cpu_rdata = cpu_rdata_reg;

endmodule
